vedic_multiplier_seq: RTL
=========================

VEDIC_MULTIPLIER_SEQ -- requirements
Module: vedic_multiplier_seq

Interface
REQ-001 Parameter DATA_WIDTH, default 8, operand width in bits; SHALL be even and >= 4.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  operand pair and mode present.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 inData_A  input  DATA_WIDTH  multiplicand.
REQ-007 inData_B  input  DATA_WIDTH  multiplier.
REQ-008 in_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with operands.
REQ-009 out_valid  output  1  outData_C holds a completed product.
REQ-010 out_ready  input  1  consumer accepts product.
REQ-011 outData_C  output  2*DATA_WIDTH  registered product.

Function
REQ-012 FSM states SHALL be IDLE, BUSY, DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-014 Accept occurs on an edge with IDLE & in_valid; A, B, and in_signed are captured, accumulator cleared, digit counter set to 0, next state BUSY.
REQ-015 On capture with in_signed=1, A and B SHALL be stored as DATA_WIDTH-bit magnitudes, and result sign = A[msb] XOR B[msb]; with in_signed=0 operands are stored unchanged, sign = 0.
REQ-016 Each BUSY edge SHALL add (magA * digit_k) << (2*k) to a 2*DATA_WIDTH accumulator; digit_k = magB[2k+1:2k], k = counter value; the 2-bit-by-N partial product uses vertical-crosswise (vedic) decomposition.
REQ-017 Counter SHALL count 0..DATA_WIDTH/2-1; on the edge processing k = DATA_WIDTH/2-1 the state becomes DONE and outData_C is loaded with the final sum, two's-complement negated if sign = 1.
REQ-018 Latency SHALL be exactly DATA_WIDTH/2 cycles from the accept edge to out_valid=1 (4 cycles at DATA_WIDTH=8).
REQ-019 In DONE, outData_C and out_valid SHALL hold stable until out_ready=1; the edge with out_valid & out_ready returns to IDLE.
REQ-020 in_valid in BUSY or DONE SHALL be ignored, with no capture and no state change.
REQ-021 Most-negative operands (e.g. -2^(N-1)) SHALL be handled exactly; the magnitude fits N unsigned bits and the product fits 2N bits, with no overflow or saturation.
REQ-022 outData_C SHALL keep its last value in IDLE and BUSY; consumers qualify it with out_valid only.
REQ-023 Throughput: at most one product per DATA_WIDTH/2+2 cycles; there is no overlap between operations.

Reset
REQ-024 Assertion of rst_n=0 SHALL immediately force: state IDLE, in_ready=1 after reset release, out_valid=0, outData_C=0, accumulator=0, counter=0, stored operands=0, sign=0.
REQ-025 Reset asserted mid-BUSY or mid-DONE SHALL abandon the operation; no product is emitted after release.
REQ-026 The first accept is possible on the first rising edge after rst_n deasserts.

Structure
REQ-027 Shared package vedic_pkg SHALL hold the state enum (IDLE/BUSY/DONE) and the constant DIGIT_W=2.
REQ-028 Sub-module vedic_mul_2xn (parameter DATA_WIDTH) SHALL be purely combinational and compute magA * 2-bit digit as a DATA_WIDTH+2 bit result; it is instantiated once.
REQ-029 Product width SHALL derive from DATA_WIDTH only; there are no hard-coded bit positions.

Verification
REQ-030 DATA_WIDTH=8, unsigned 255*255 -> out_valid 4 cycles after accept, outData_C=0xFE01.
REQ-031 Signed -128*-128 -> 0x4000; signed -3*5 -> 0xFFF1; signed 127*-1 -> 0xFF81.
REQ-032 Backpressure: out_ready=0 for 3 cycles after out_valid -> outData_C/out_valid stable and in_ready=0 throughout; IDLE the cycle after out_ready=1.
REQ-033 in_valid held high with new operands during BUSY -> the original product (e.g. 12*10=0x0078) is unaffected, and the new pair is accepted only once IDLE.
REQ-034 rst_n pulsed low during BUSY (k=2) -> out_valid never rises for that operation, outData_C=0, and in_ready=1 after release.
REQ-035 Random regression at DATA_WIDTH=4, 8, 16 against a reference model for both modes, including 0 operands -> all match; 0*x = 0.

Source files
------------

// File: rtl/vedic_pkg.sv
// rtl/vedic_pkg.sv - shared types and constants for the sequential vedic multiplier
// Purpose: FSM state encoding and the digit width used by the 2-bit-per-cycle datapath.
// Ports: none (package).
package vedic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Multiplier bits consumed per BUSY cycle.
    localparam int DIGIT_W = 2;

endpackage

// File: rtl/vedic_mul_2xn.sv
// rtl/vedic_mul_2xn.sv - combinational N-bit by 2-bit vedic partial product
// Purpose: product = a * digit using vertical-crosswise (urdhva tiryagbhyam) columns.
// Ports:
//   a       - DATA_WIDTH-bit unsigned multiplicand
//   digit   - DIGIT_W-bit unsigned multiplier digit
//   product - DATA_WIDTH+2 bit result
module vedic_mul_2xn
    import vedic_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0]   a,
    input  logic [DIGIT_W-1:0]      digit,
    output logic [DATA_WIDTH+1:0]   product
);

    // Column i sums the vertical term a[i]*d0 and the crosswise term a[i-1]*d1.
    // Zero-padded copies keep every column index in range without special cases.
    logic [DATA_WIDTH:0] a_vert;
    logic [DATA_WIDTH:0] a_cross;

    assign a_vert  = {1'b0, a};
    assign a_cross = {a, 1'b0};

    always_comb begin
        logic       carry;
        logic [1:0] col;
        product = '0;
        carry   = 1'b0;
        col     = '0;
        for (int i = 0; i <= DATA_WIDTH; i++) begin
            // Two partial bits plus an incoming carry never exceed 3, so a 1-bit carry suffices.
            col = {1'b0, a_vert[i] & digit[0]}
                + {1'b0, a_cross[i] & digit[1]}
                + {1'b0, carry};
            product[i] = col[0];
            carry      = col[1];
        end
        product[DATA_WIDTH+1] = carry;
    end

endmodule

// File: rtl/vedic_multiplier_seq.sv
// rtl/vedic_multiplier_seq.sv - sequential signed/unsigned multiplier, one 2-bit digit per cycle
// Purpose: accepts an operand pair in IDLE, accumulates DATA_WIDTH/2 vedic partial products
//          in BUSY, and presents the registered product in DONE until consumed.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   in_valid / in_ready   - operand handshake (in_ready only in IDLE)
//   inData_A, inData_B    - multiplicand / multiplier
//   in_signed             - 1 = two's-complement operands
//   out_valid / out_ready - product handshake (out_valid only in DONE)
//   outData_C             - registered 2*DATA_WIDTH product
module vedic_multiplier_seq
    import vedic_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     inData_A,
    input  logic [DATA_WIDTH-1:0]     inData_B,
    input  logic                      in_signed,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2*DATA_WIDTH-1:0]   outData_C
);

    localparam int PW   = 2 * DATA_WIDTH;
    localparam int NDIG = DATA_WIDTH / DIGIT_W;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    state_t                 state;
    logic [DATA_WIDTH-1:0]  mag_a;
    logic [DATA_WIDTH-1:0]  mag_b;
    logic                   sign;
    logic [PW-1:0]          acc;
    logic [CW-1:0]          cnt;

    logic [DATA_WIDTH-1:0]  a_abs;
    logic [DATA_WIDTH-1:0]  b_abs;
    logic [DATA_WIDTH-1:0]  b_shifted;
    logic [DIGIT_W-1:0]     digit;
    logic [DATA_WIDTH+1:0]  pp;
    logic [PW-1:0]          pp_shifted;
    logic [PW-1:0]          acc_next;
    logic                   last_digit;

    // Magnitudes are taken at capture; -2^(N-1) maps to 2^(N-1), which still fits N unsigned bits.
    assign a_abs = (in_signed && inData_A[DATA_WIDTH-1]) ? (~inData_A + DATA_WIDTH'(1)) : inData_A;
    assign b_abs = (in_signed && inData_B[DATA_WIDTH-1]) ? (~inData_B + DATA_WIDTH'(1)) : inData_B;

    assign b_shifted  = mag_b >> (DIGIT_W * cnt);
    assign digit      = b_shifted[DIGIT_W-1:0];
    assign pp_shifted = PW'(pp) << (DIGIT_W * cnt);
    assign acc_next   = acc + pp_shifted;
    assign last_digit = (cnt == CW'(NDIG - 1));

    vedic_mul_2xn #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mul (
        .a       (mag_a),
        .digit   (digit),
        .product (pp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            outData_C <= '0;
            mag_a     <= '0;
            mag_b     <= '0;
            sign      <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mag_a    <= a_abs;
                        mag_b    <= b_abs;
                        sign     <= in_signed & (inData_A[DATA_WIDTH-1] ^ inData_B[DATA_WIDTH-1]);
                        acc      <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    acc <= acc_next;
                    if (last_digit) begin
                        outData_C <= sign ? (-acc_next) : acc_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
